booth_mult_seq: RTL and testbench

Parametrised sequential Booth multiplier, the successor to our fixed 8-bit signed Booth unit. It supports any operand width, signed or unsigned operands selected per operation, and either radix-2 or radix-4 (modified Booth) recoding. It sits behind a start/busy/done handshake so the datapath controller can issue operations back-to-back without external sequencing.

---
 rtl/booth_mult_seq.sv | 104 ++++++++++
 tb/tb_booth_mult_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, radix-2 or radix-4, signed/unsigned per operation.
// One start/busy/done handshake; a start in the FIN cycle chains the next operation.
module booth_mult_seq #(
  parameter int WIDTH  = 8,
  parameter int RADIX4 = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int N    = (RADIX4 != 0) ? (WIDTH + 2) / 2 : WIDTH + 1;
  localparam int BW   = (RADIX4 != 0) ? 2 * N : WIDTH + 1;
  localparam int AW   = WIDTH + 3;
  localparam int CW   = AW + BW;
  localparam int SH   = (RADIX4 != 0) ? 2 : 1;
  localparam int CNTW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        acc, m, term, sum;
  logic [BW-1:0]        mq;
  logic                 hist;
  logic [CNTW-1:0]      cnt;
  logic signed [CW-1:0] shifted;
  logic                 accept, last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CNTW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Booth recoding of the low multiplier bits plus history, then add and shift.
  always_comb begin
    term = '0;
    if (RADIX4 != 0) begin
      case ({mq[1], mq[0], hist})
        3'b001, 3'b010: term = m;
        3'b011:         term = m << 1;
        3'b100:         term = -(m << 1);
        3'b101, 3'b110: term = -m;
        default:        term = '0;
      endcase
    end else begin
      case ({mq[0], hist})
        2'b01:   term = m;
        2'b10:   term = -m;
        default: term = '0;
      endcase
    end
    sum     = acc + term;
    shifted = $signed({sum, mq}) >>> SH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      m    <= '0;
      mq   <= '0;
      hist <= 1'b0;
      cnt  <= '0;
      prod <= '0;
    end else if (accept) begin
      acc  <= '0;
      hist <= 1'b0;
      cnt  <= CNTW'(N);
      m    <= {{3{is_signed & a[WIDTH-1]}}, a};
      mq   <= {{(BW-WIDTH){is_signed & b[WIDTH-1]}}, b};
    end else if (state == RUN) begin
      acc  <= shifted[CW-1:BW];
      mq   <= shifted[BW-1:0];
      hist <= (RADIX4 != 0) ? mq[1] : mq[0];
      cnt  <= cnt - CNTW'(1);
      // prod only moves on the finishing edge so it stays stable through RUN
      if (last) prod <= shifted[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: eight instances (WIDTH 8/2/7/16 x radix-2/4) checked
// through a scoreboard of expected products and due cycles.
module tb_booth_mult_seq;

  localparam int NI = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    start_v;
  logic [15:0]      a_v [NI];
  logic [15:0]      b_v [NI];
  logic [NI-1:0]    sg_v;
  logic [NI-1:0]    busy_v, done_v;
  logic [31:0]      prod_v [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          g;
    logic [31:0] p;
    int          due;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int W = (g < 2) ? 8 : (g < 4) ? 2 : (g < 6) ? 7 : 16;
    localparam int R = g % 2;
    logic [2*W-1:0] p;
    booth_mult_seq #(.WIDTH(W), .RADIX4(R)) dut (
      .clk(clk), .rst(rst), .start(start_v[g]),
      .a(a_v[g][W-1:0]), .b(b_v[g][W-1:0]), .is_signed(sg_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .prod(p)
    );
    assign prod_v[g] = 32'(p);
  end

  function automatic int wof(int g);
    return (g < 2) ? 8 : (g < 4) ? 2 : (g < 6) ? 7 : 16;
  endfunction

  function automatic int nof(int g);
    return (g % 2 == 1) ? (wof(g) + 2) / 2 : wof(g) + 1;
  endfunction

  function automatic logic [31:0] ref_mul(int w, logic [15:0] av, logic [15:0] bv, logic s);
    longint x, y, p, msk;
    msk = (longint'(1) << w) - 1;
    x = longint'(av) & msk;
    y = longint'(bv) & msk;
    if (s && av[w-1]) x = x - (longint'(1) << w);
    if (s && bv[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding entry for that instance.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NI; g++) begin
        if (done_v[g]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].g == g) idx = i;
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_done g=%0d prod=%h", g, prod_v[g]);
          end else begin
            if (prod_v[g] !== sb[idx].p) begin
              failures++;
              $display("FAIL prod g=%0d got=%h exp=%h", g, prod_v[g], sb[idx].p);
            end
            checks++;
            if (cyc !== sb[idx].due) begin
              failures++;
              $display("FAIL latency g=%0d got_cycle=%0d exp_cycle=%0d", g, cyc, sb[idx].due);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end

  // Caller is at a negedge; drives one start pulse and records what should come back.
  task automatic issue(int g, logic [15:0] av, logic [15:0] bv, logic s, logic [31:0] exp);
    a_v[g] = av; b_v[g] = bv; sg_v[g] = s; start_v[g] = 1'b1;
    @(posedge clk); #1;
    start_v[g] = 1'b0;
    sb.push_back('{g: g, p: exp, due: cyc + nof(g)});
  endtask

  task automatic wait_idle(input int bound, output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) timeout = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0;
    sg_v = '0;
    for (int g = 0; g < NI; g++) begin a_v[g] = '0; b_v[g] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (prod_v[g] !== 32'h0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state g=%0d prod=%h busy=%b done=%b exp 0/0/0",
                 g, prod_v[g], busy_v[g], done_v[g]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [8] = '{16'hFD, 16'h80, 16'h80, 16'h00, 16'hFF, 16'h80, 16'hFF, 16'h80};
    logic [15:0] tb [8] = '{16'h05, 16'h80, 16'h7F, 16'hFF, 16'hFF, 16'h02, 16'hFF, 16'h02};
    logic        ts [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] te [8] = '{32'hFFF1, 32'h4000, 32'hC080, 32'h0000,
                            32'hFE01, 32'h0100, 32'h0001, 32'hFF00};
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 8; i++) begin
        logic [31:0] hold;
        bit moved;
        int n;
        @(negedge clk);
        hold = prod_v[g];
        moved = 1'b0;
        issue(g, ta[i], tb[i], ts[i], te[i]);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
          @(negedge clk);
          n++;
          if (busy_v[g] && prod_v[g] !== hold) moved = 1'b1;
        end
        checks++;
        if (sb.size() != 0) begin
          failures++;
          $display("FAIL directed_timeout g=%0d vec=%0d pending=%0d exp 0", g, i, sb.size());
          sb.delete();
        end
        checks++;
        if (moved !== 1'b0) begin
          failures++;
          $display("FAIL prod_stable g=%0d vec=%0d moved=%b exp 0", g, i, moved);
        end
      end
    end
  endtask

  task automatic test_handshake();
    int n;
    bit to;
    @(negedge clk);
    issue(0, 16'h11, 16'h03, 1'b0, 32'h0033);
    repeat (2) @(negedge clk);
    a_v[0] = 16'h22; b_v[0] = 16'h22; sg_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_ignored_start got=%b exp=1", busy_v[0]);
    end
    n = 0;
    while (!done_v[0] && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL fin_wait done=%b exp=1", done_v[0]);
    end else begin
      issue(0, 16'h06, 16'h07, 1'b0, 32'h002A);
      @(negedge clk);
      checks++;
      if (busy_v[0] !== 1'b1) begin
        failures++;
        $display("FAIL busy_after_fin_start got=%b exp=1", busy_v[0]);
      end
    end
    wait_idle(60, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL handshake_timeout pending=%0d exp 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit to;
    @(negedge clk);
    a_v[0] = 16'd100; b_v[0] = 16'd100; sg_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (prod_v[0] !== 32'h0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid prod=%h busy=%b done=%b exp 0/0/0", prod_v[0], busy_v[0], done_v[0]);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL done_after_abort got=%b exp=0", seen);
    end
    @(negedge clk);
    issue(0, 16'h02, 16'h03, 1'b1, 32'h0006);
    wait_idle(40, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL reset_mid_timeout pending=%0d exp 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_sweep();
    int rem [NI];
    int k [NI];
    bit pend [NI];
    logic [31:0] ex [NI];
    int guard;
    bit any_rem, any_pend, to;
    for (int g = 0; g < NI; g++) begin rem[g] = 2000; k[g] = 0; end
    guard = 0;
    any_rem = 1'b1;
    while (any_rem && guard < 60000) begin
      @(negedge clk);
      guard++;
      any_pend = 1'b0;
      for (int g = 0; g < NI; g++) begin
        pend[g] = 1'b0;
        if (!busy_v[g] && rem[g] > 0) begin
          int w;
          logic [15:0] msk, av, bv;
          logic s;
          w = wof(g);
          msk = 16'((32'd1 << w) - 1);
          if (k[g] < 8) begin
            av = k[g][0] ? msk : 16'(1 << (w - 1));
            bv = k[g][1] ? msk : 16'(1 << (w - 1));
            s  = k[g][2];
          end else begin
            av = 16'($urandom) & msk;
            bv = 16'($urandom) & msk;
            s  = k[g][0];
          end
          a_v[g] = av; b_v[g] = bv; sg_v[g] = s; start_v[g] = 1'b1;
          ex[g] = ref_mul(w, av, bv, s);
          pend[g] = 1'b1;
          any_pend = 1'b1;
          rem[g]--;
          k[g]++;
        end
      end
      if (any_pend) begin
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
          if (pend[g]) begin
            start_v[g] = 1'b0;
            sb.push_back('{g: g, p: ex[g], due: cyc + nof(g)});
          end
        end
      end
      any_rem = 1'b0;
      for (int g = 0; g < NI; g++) if (rem[g] > 0) any_rem = 1'b1;
    end
    checks++;
    if (any_rem) begin
      failures++;
      $display("FAIL sweep_issue_timeout guard=%0d exp all issued", guard);
    end
    wait_idle(100, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL sweep_drain_timeout pending=%0d exp 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_reset_mid();
    test_sweep();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
